// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-drain UART transmitter.
package fifo_uart_pkg;

  localparam int DATA_W          = 8;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    cnt_d   = cnt_q + CNT_W'(1);
    if (clear || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the synchronous FIFO read port and sends each as a UART 8N1 frame.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = fifo_uart_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              tx_done,
  output tx_state_t         state_dbg
);

  // Last data-bit index: frame bits minus start, stop, and the zero-based offset.
  localparam logic [2:0] LAST_BIT = 3'(UART_FRAME_BITS - 3);

  tx_state_t         state_q, state_d;
  logic              fifo_rd_q, fifo_rd_d;
  logic              tx_q, tx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              baud_clear;
  logic              bit_end;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock  (clock),
    .rst_n  (rst_n),
    .clear  (baud_clear),
    .bit_end(bit_end)
  );

  // FIFO read handshake: fifo_rd is a one-clock strobe raised only from IDLE
  // with fifo_empty low; the FIFO samples it on the following edge and drives
  // fifo_data after that edge, so the byte is captured in RD_WAIT.
  always_comb begin
    state_d    = state_q;
    fifo_rd_d  = 1'b0;
    tx_d       = tx_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    baud_clear = 1'b1;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (enable && !fifo_empty) begin
          fifo_rd_d = 1'b1;
          state_d   = RD_REQ;
        end
      end
      RD_REQ: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        shift_d   = fifo_data;
        tx_d      = 1'b0;
        bit_idx_d = '0;
        state_d   = START;
      end
      START: begin
        baud_clear = 1'b0;
        if (bit_end) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = DATA;
        end
      end
      DATA: begin
        baud_clear = 1'b0;
        if (bit_end) begin
          if (bit_idx_q == LAST_BIT) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        baud_clear = 1'b0;
        if (bit_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      fifo_rd_q <= 1'b0;
      tx_q      <= 1'b1;
      shift_q   <= '0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      fifo_rd_q <= fifo_rd_d;
      tx_q      <= tx_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  assign fifo_rd   = fifo_rd_q;
  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign tx_done   = (state_q == STOP) && bit_end;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed + random bench for fifo_uart_tx draining a behavioural 32x8 synchronous FIFO.
module tb_fifo_uart_tx;
  import fifo_uart_pkg::*;

  localparam int CPB        = 4;
  localparam int FRAME_CLKS = 10 * CPB;
  localparam int WAIT_LIMIT = 200;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic       tx_done;
  tx_state_t  state_dbg;

  logic       wr_en;
  logic [7:0] wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (8)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done),
    .state_dbg (state_dbg)
  );

  // Behavioural 32-deep FIFO: rd sampled at an edge, data_out valid after it.
  logic [7:0] mem [32];
  logic [4:0] wp = '0;
  logic [4:0] rp = '0;
  logic [5:0] fifo_count = '0;
  logic       do_push;
  logic       do_pop;
  int         bad_pops = 0;

  assign fifo_empty = (fifo_count == 6'd0);
  assign do_push    = wr_en && (fifo_count < 6'd32);
  assign do_pop     = fifo_rd && (fifo_count != 6'd0);

  always @(posedge clock) begin
    if (do_push) begin
      mem[wp] <= wr_data;
      wp      <= wp + 5'd1;
    end
    if (do_pop) begin
      fifo_data <= mem[rp];
      rp        <= rp + 5'd1;
    end
    if (fifo_rd && fifo_count == 6'd0) bad_pops <= bad_pops + 1;
    fifo_count <= fifo_count + 6'(do_push) - 6'(do_pop);
  end

  // Observation counters for read strobes and done pulses.
  int   rd_cycles = 0;
  int   rd_pulses = 0;
  int   done_cnt  = 0;
  logic rd_prev   = 1'b0;

  always @(posedge clock) begin
    if (fifo_rd === 1'b1) rd_cycles <= rd_cycles + 1;
    if (fifo_rd === 1'b1 && rd_prev !== 1'b1) rd_pulses <= rd_pulses + 1;
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    rd_prev <= fifo_rd;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
    exp_q.push_back(b);
  endtask

  // Waits for the start bit, then checks every cycle of the frame against
  // {stop, data LSB-first, start}. Optional enable drop / reset at a frame cycle.
  task automatic expect_frame(input int drop_c, input int rst_c, output int w);
    logic [7:0] b;
    logic [9:0] fr;
    if (exp_q.size() == 0) begin
      check("model_queue_empty", 32'(exp_q.size()), 32'd1);
      w = WAIT_LIMIT;
      return;
    end
    b  = exp_q.pop_front();
    fr = {1'b1, b, 1'b0};
    w  = 0;
    while (tx !== 1'b0 && w < WAIT_LIMIT) begin
      tick();
      w++;
    end
    check("frame_start_timeout", 32'(w < WAIT_LIMIT), 32'd1);
    if (w >= WAIT_LIMIT) return;
    for (int c = 1; c <= FRAME_CLKS; c++) begin
      if (c == drop_c) enable = 1'b0;
      check("tx_bit", 32'(tx), 32'(fr[(c - 1) / CPB]));
      check("tx_done", 32'(tx_done), 32'(c == FRAME_CLKS));
      check("busy_in_frame", 32'(busy), 32'd1);
      if (c == rst_c) begin
        rst_n = 1'b0;
        tick();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        rst_n = 1'b1;
        return;
      end
      tick();
    end
    check("post_frame_tx", 32'(tx), 32'd1);
    check("post_frame_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int w;
    int rd0;
    int done0;
    int bad;
    rst_n   = 1'b0;
    enable  = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    tick();
    tick();

    // Reset held with a non-empty FIFO: nothing moves.
    enable = 1'b1;
    push_byte(8'hA5);
    for (int i = 0; i < 3; i++) begin
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_fifo_rd", 32'(fifo_rd), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_tx_done", 32'(tx_done), 32'd0);
      check("reset_state", 32'(state_dbg), 32'(IDLE));
      tick();
    end
    check("reset_no_pop", 32'(rd_cycles), 32'd0);
    check("reset_fifo_count", 32'(fifo_count), 32'd1);

    // Single byte.
    rst_n = 1'b1;
    expect_frame(0, 0, w);
    check("single_rd_pulses", 32'(rd_pulses), 32'd1);
    check("single_rd_cycles", 32'(rd_cycles), 32'd1);
    check("single_done_cnt", 32'(done_cnt), 32'd1);
    check("single_fifo_empty", 32'(fifo_empty), 32'd1);

    // Back-to-back 0x00 / 0xFF with a 3-clock gap.
    enable = 1'b0;
    push_byte(8'h00);
    push_byte(8'hFF);
    rd0 = rd_pulses; done0 = done_cnt;
    enable = 1'b1;
    expect_frame(0, 0, w);
    expect_frame(0, 0, w);
    check("b2b_gap", 32'(w), 32'd3);
    check("b2b_rd_pulses", 32'(rd_pulses - rd0), 32'd2);
    check("b2b_rd_width", 32'(rd_cycles), 32'(rd_pulses));
    check("b2b_done_cnt", 32'(done_cnt - done0), 32'd2);

    // Empty FIFO with enable high, then data with enable low.
    rd0 = rd_cycles; bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (fifo_rd !== 1'b0 || tx !== 1'b1) bad++;
    end
    check("empty_idle_violations", 32'(bad), 32'd0);
    enable = 1'b0;
    push_byte(8'h3C);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fifo_rd !== 1'b0 || tx !== 1'b1) bad++;
    end
    check("disabled_idle_violations", 32'(bad), 32'd0);
    check("disabled_no_pop", 32'(rd_cycles - rd0), 32'd0);
    check("disabled_fifo_count", 32'(fifo_count), 32'd1);
    enable = 1'b1;
    expect_frame(0, 0, w);

    // Enable dropped during DATA bit 2 of the first frame.
    enable = 1'b0;
    push_byte(8'h11);
    push_byte(8'h22);
    enable = 1'b1;
    expect_frame(3 * CPB + 2, 0, w);
    rd0 = rd_cycles;
    for (int i = 0; i < 20; i++) tick();
    check("drop_no_pop", 32'(rd_cycles - rd0), 32'd0);
    check("drop_fifo_empty", 32'(fifo_empty), 32'd0);
    check("drop_fifo_count", 32'(fifo_count), 32'd1);
    enable = 1'b1;
    expect_frame(0, 0, w);

    // Reset during DATA bit 3 of 0x5A with 0x77 queued.
    enable = 1'b0;
    push_byte(8'h5A);
    push_byte(8'h77);
    done0 = done_cnt;
    enable = 1'b1;
    expect_frame(0, 4 * CPB + 2, w);
    check("abort_no_done", 32'(done_cnt - done0), 32'd0);
    expect_frame(0, 0, w);
    check("after_abort_done", 32'(done_cnt - done0), 32'd1);

    // Random burst.
    enable = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'($urandom_range(0, 255)));
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      expect_frame(0, 0, w);
      if (i > 0) check("rand_gap", 32'(w), 32'd3);
    end

    check("final_fifo_empty", 32'(fifo_empty), 32'd1);
    check("final_rd_width", 32'(rd_cycles), 32'(rd_pulses));
    check("no_pop_while_empty", 32'(bad_pops), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
